// File: rtl/ctr_cmd_sequencer_if.sv
// Host command channel for ctr_cmd_sequencer: valid/ready handshake carrying opcode, load value and cycle count.
interface ctr_cmd_sequencer_if #(
    parameter int ARG_W = 4,
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ARG_W-1:0] cmd_arg;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, cmd_op, cmd_arg, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_arg, cmd_len, output cmd_ready);
endinterface

// File: rtl/ctr_cmd_sequencer.sv
// Buffers CLEAR/LOAD/UP/DOWN commands and replays them as mod-12 counter control waveforms.
// Optional feature macro: CMD_LOAD_CLAMP_EN clamps LOAD values above 11 to 11.
module ctr_cmd_sequencer #(
    parameter int ARG_W  = 4,
    parameter int LEN_W  = 8,
    parameter int QDEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    ctr_cmd_sequencer_if.slave   cmd,
    output logic                 ctr_reset,
    output logic                 ctr_load,
    output logic [ARG_W-1:0]     ctr_din,
    output logic                 ctr_mode,
    output logic                 done,
    output logic                 busy
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, RUN} state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [ARG_W-1:0] arg;
        logic [LEN_W-1:0] len;
    } entry_t;

    function automatic logic [ARG_W-1:0] clamp_arg(input logic [ARG_W-1:0] a);
`ifdef CMD_LOAD_CLAMP_EN
        return (32'(a) > 32'd11) ? ARG_W'(11) : a;
`else
        return a;
`endif
    endfunction

    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

    entry_t           mem_q [QDEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             pulse_q, pulse_d;
    logic             load_q, load_d;
    logic [ARG_W-1:0] din_q, din_d;
    logic             mode_q, mode_d;

    logic   empty, full, push, pop, last_cycle;
    entry_t head, wr_entry;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Ready comes from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign cmd.cmd_ready = !full && !reset;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_entry   = '{op: cmd.cmd_op, arg: cmd.cmd_arg, len: cmd.cmd_len};
    assign last_cycle = (state_q == PULSE) || ((state_q == RUN) && (rem_q == LEN_W'(1)));
    assign pop        = !empty && ((state_q == IDLE) || last_cycle);

    assign ctr_reset = reset | pulse_q;
    assign ctr_load  = load_q;
    assign ctr_din   = din_q;
    assign ctr_mode  = mode_q;
    assign done      = last_cycle && !reset;
    assign busy      = (state_q != IDLE) || !empty;

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        pulse_d  = 1'b0;
        load_d   = 1'b0;
        din_d    = din_q;
        mode_d   = mode_q;
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

        if (pop) begin
            case (head.op)
                2'd0: begin
                    state_d = PULSE;
                    pulse_d = 1'b1;
                end
                2'd1: begin
                    state_d = PULSE;
                    load_d  = 1'b1;
                    din_d   = clamp_arg(head.arg);
                end
                2'd2: begin
                    state_d = RUN;
                    mode_d  = 1'b1;
                    rem_d   = eff_len(head.len);
                end
                default: begin
                    state_d = RUN;
                    mode_d  = 1'b0;
                    rem_d   = eff_len(head.len);
                end
            endcase
        end else if (last_cycle) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            rem_d = rem_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pulse_q  <= 1'b0;
            load_q   <= 1'b0;
            din_q    <= '0;
            mode_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pulse_q  <= pulse_d;
            load_q   <= load_d;
            din_q    <= din_d;
            mode_q   <= mode_d;
        end
    end

    // Datapath storage is not reset; the state and pointers qualify it.
    always_ff @(posedge clock) begin
        rem_q <= rem_d;
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
endmodule

// File: tb/tb_ctr_cmd_sequencer.sv
// Randomized bench for ctr_cmd_sequencer against a command-timeline reference model.
module tb_ctr_cmd_sequencer;
    localparam int ARG_W  = 4;
    localparam int LEN_W  = 8;
    localparam int QDEPTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             ctr_reset, ctr_load, ctr_mode, done, busy;
    logic [ARG_W-1:0] ctr_din;

    ctr_cmd_sequencer_if #(.ARG_W(ARG_W), .LEN_W(LEN_W)) cmd_bus ();

    ctr_cmd_sequencer #(.ARG_W(ARG_W), .LEN_W(LEN_W), .QDEPTH(QDEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cmd_bus),
        .ctr_reset (ctr_reset),
        .ctr_load  (ctr_load),
        .ctr_din   (ctr_din),
        .ctr_mode  (ctr_mode),
        .done      (done),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Each accepted command occupies the cycle window [start, last].
    typedef struct {
        int op;
        int arg;
        int len;
        int start;
        int last;
    } cmd_t;

    cmd_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;
    int   mode_m = 1;
    int   din_m  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic int clamp(input int a);
`ifdef CMD_LOAD_CLAMP_EN
        return (a > 11) ? 11 : a;
`else
        return a;
`endif
    endfunction

    task automatic step(input bit rst, input bit v, input int op, input int arg, input int len,
                        output bit acc);
        int   e_reset, e_load, e_done, e_busy, e_ready, occ, s, d;
        cmd_t c;
        @(posedge clock);
        k++;
        #1;
        reset             = rst;
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_op    = 2'(op);
        cmd_bus.cmd_arg   = ARG_W'(arg);
        cmd_bus.cmd_len   = LEN_W'(len);

        while (q.size() > 0 && q[0].last < k) void'(q.pop_front());
        e_reset = rst; e_load = 0; e_done = 0; e_busy = 0; occ = 0;
        foreach (q[i]) begin
            if (q[i].start == k) begin
                if (q[i].op == 1) din_m = clamp(q[i].arg);
                if (q[i].op == 2) mode_m = 1;
                if (q[i].op == 3) mode_m = 0;
            end
            if (q[i].start <= k && k <= q[i].last) begin
                if (q[i].op == 0) e_reset = 1;
                if (q[i].op == 1) e_load = 1;
                if (k == q[i].last && !rst) e_done = 1;
            end
            if (q[i].last >= k) e_busy = 1;
            if (q[i].start > k) occ++;
        end
        e_ready = (!rst && occ < QDEPTH) ? 1 : 0;

        @(negedge clock);
        check("ctr_reset", 32'(ctr_reset), 32'(e_reset));
        check("ctr_load",  32'(ctr_load),  32'(e_load));
        check("ctr_din",   32'(ctr_din),   32'(din_m));
        check("ctr_mode",  32'(ctr_mode),  32'(mode_m));
        check("done",      32'(done),      32'(e_done));
        check("busy",      32'(busy),      32'(e_busy));
        check("cmd_ready", 32'(cmd_bus.cmd_ready), 32'(e_ready));

        acc = 1'b0;
        if (rst) begin
            q.delete();
            mode_m = 1;
            din_m  = 0;
        end else if (v && e_ready != 0) begin
            acc = 1'b1;
            s = k + 2;
            if (q.size() > 0 && q[$].last + 1 > s) s = q[$].last + 1;
            d = (op < 2) ? 1 : ((len == 0) ? 1 : len);
            c.op = op; c.arg = arg; c.len = len; c.start = s; c.last = s + d - 1;
            q.push_back(c);
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, a);
    endtask

    task automatic push_cmd(input int op, input int arg, input int len);
        bit a;
        int n;
        a = 1'b0;
        n = 0;
        while (!a && n < 200) begin
            step(1'b0, 1'b1, op, arg, len, a);
            n++;
        end
        check("push_accepted", 32'(a), 32'd1);
    endtask

    initial begin
        bit a;
        reset             = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = '0;
        cmd_bus.cmd_arg   = '0;
        cmd_bus.cmd_len   = '0;

        step(1'b1, 1'b0, 0, 0, 0, a);
        step(1'b1, 1'b0, 0, 0, 0, a);
        idle(2);

        push_cmd(1, 5, 0);
        idle(4);
        push_cmd(2, 0, 3);
        push_cmd(3, 0, 2);
        idle(8);

        push_cmd(2, 0, 20);
        for (int i = 0; i < 5; i++) push_cmd(i % 4, 3 + i, 2);
        idle(40);

        push_cmd(2, 0, 10);
        push_cmd(1, 7, 0);
        push_cmd(3, 0, 4);
        idle(3);
        step(1'b1, 1'b0, 0, 0, 0, a);
        idle(6);

        push_cmd(1, 14, 0);
        push_cmd(2, 0, 0);
        push_cmd(0, 0, 0);
        push_cmd(3, 0, 0);
        idle(8);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 6)), a);
        end
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
